// File: rtl/seq_controller.sv
// Phase-sequencing controller for the accumulator CPU.
// Owns a 3-bit instruction phase counter and decodes the nine datapath
// control strobes from the phase and the current IR opcode. Memory-final
// phases can be stretched by mem_ready with a wait-state timeout that
// parks the controller in a bus-error state. HLT parks it in a halted
// state that `run` may optionally leave.
module seq_controller #(
  parameter int WAIT_W    = 4,
  parameter int MAX_WAIT  = 15,
  parameter int RESUME_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       run,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] phase,
  output logic       stall,
  output logic       halted,
  output logic       bus_err
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StError  = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] MaxWaitCnt = WAIT_W'(MAX_WAIT);
  localparam logic              TimeoutEn  = (MAX_WAIT != 0);
  localparam logic              ResumeOk   = (RESUME_EN != 0);

  state_e            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic isHlt, isSkz, isAlu, isSto, isJmp;
  logic memFinal, stallNow, timeoutNow, haltNow;

  // Opcode classes and the per-cycle conditions derived from phase and state.
  always_comb begin
    isHlt      = (opcode == 3'b000);
    isSkz      = (opcode == 3'b001);
    isAlu      = (opcode >= 3'b010) && (opcode <= 3'b101);
    isSto      = (opcode == 3'b110);
    isJmp      = (opcode == 3'b111);
    memFinal   = (phase_q == 3'd3) || ((phase_q == 3'd7) && (isAlu || isSto));
    stallNow   = (state_q == StRun) && memFinal && !mem_ready;
    timeoutNow = stallNow && TimeoutEn && (wait_q == MaxWaitCnt);
    haltNow    = (state_q == StRun) && (phase_q == 3'd4) && isHlt;
  end

  // State, phase and wait-counter registers; reset restarts a fresh fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      phase_q <= 3'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic. A stalled cycle holds the phase and counts a wait
  // state; a timeout takes priority over everything else in RUN. Halt can
  // never coincide with a stall because phase 4 is not memory-final.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = '0;
    unique case (state_q)
      StRun: begin
        if (timeoutNow) begin
          state_d = StError;
        end else if (stallNow) begin
          wait_d = wait_q + WAIT_W'(1);
        end else if (haltNow) begin
          state_d = StHalted;
          phase_d = 3'd0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      StHalted: begin
        phase_d = 3'd0;
        if (ResumeOk && run) begin
          state_d = StRun;
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StError;
      end
    endcase
  end

  // Strobe decode. Only RUN drives strobes; during a stall the decode is
  // simply re-evaluated for the held phase, so the strobes stay put.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (state_q == StRun) begin
      unique case (phase_q)
        3'd0: begin
          sel = 1'b1;
        end
        3'd1: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        3'd2, 3'd3: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        3'd4: begin
          inc_pc = 1'b1;
          halt   = isHlt;
        end
        3'd5: begin
          rd = isAlu;
        end
        3'd6: begin
          rd     = isAlu;
          inc_pc = isSkz && zero;
          ld_pc  = isJmp;
          data_e = isSto;
        end
        3'd7: begin
          rd     = isAlu;
          ld_ac  = isAlu;
          ld_pc  = isJmp;
          wr     = isSto;
          data_e = isSto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  // Status outputs straight from registered state.
  always_comb begin
    phase   = phase_q;
    stall   = stallNow;
    halted  = (state_q != StRun);
    bus_err = (state_q == StError);
  end

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller.
// Instance A: MAX_WAIT=3, RESUME_EN=1 (timeout and resume behaviour).
// Instance B: MAX_WAIT=0, RESUME_EN=0 (timeout disabled, halt is sticky).
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       memReady;
  logic       run;

  wire [8:0] aStrobes;
  wire [2:0] aPhase;
  wire       aStall, aHalted, aBusErr;
  wire [8:0] bStrobes;
  wire [2:0] bPhase;
  wire       bStall, bHalted, bBusErr;

  int checks   = 0;
  int failures = 0;

  // strobe vector order: {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
  typedef struct packed {
    logic [2:0] op;
    logic       z;
    logic       mr;
    logic [2:0] ph;
    logic [8:0] stb;
    logic       st;
  } vec_t;

  vec_t vecs[$];

  seq_controller #(.WAIT_W(4), .MAX_WAIT(3), .RESUME_EN(1)) dutA (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(memReady), .run(run),
    .sel(aStrobes[8]), .rd(aStrobes[7]), .ld_ir(aStrobes[6]),
    .halt(aStrobes[5]), .inc_pc(aStrobes[4]), .ld_ac(aStrobes[3]),
    .ld_pc(aStrobes[2]), .wr(aStrobes[1]), .data_e(aStrobes[0]),
    .phase(aPhase), .stall(aStall), .halted(aHalted), .bus_err(aBusErr)
  );

  seq_controller #(.WAIT_W(4), .MAX_WAIT(0), .RESUME_EN(0)) dutB (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(memReady), .run(run),
    .sel(bStrobes[8]), .rd(bStrobes[7]), .ld_ir(bStrobes[6]),
    .halt(bStrobes[5]), .inc_pc(bStrobes[4]), .ld_ac(bStrobes[3]),
    .ld_pc(bStrobes[2]), .wr(bStrobes[1]), .data_e(bStrobes[0]),
    .phase(bPhase), .stall(bStall), .halted(bHalted), .bus_err(bBusErr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic addVec(input logic [2:0] op, input logic z, input logic mr,
                        input logic [2:0] ph, input logic [8:0] stb, input logic st);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.ph = ph; v.stb = stb; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic z,
                               input logic mr, input logic r);
    opcode   = op;
    zero     = z;
    memReady = mr;
    run      = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Full status check of instance A.
  task automatic checkA(input string tag, input logic [2:0] ph, input logic [8:0] stb,
                        input logic st, input logic hl, input logic be);
    checkOutput({tag, " phase"},   32'(aPhase),   32'(ph));
    checkOutput({tag, " strobes"}, 32'(aStrobes), 32'(stb));
    checkOutput({tag, " stall"},   32'(aStall),   32'(st));
    checkOutput({tag, " halted"},  32'(aHalted),  32'(hl));
    checkOutput({tag, " bus_err"}, 32'(aBusErr),  32'(be));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rstPulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Standard fetch phases 0..3 with no wait states.
  task automatic addFetch(input logic [2:0] op, input logic z);
    addVec(op, z, 1'b1, 3'd0, 9'b100000000, 1'b0);
    addVec(op, z, 1'b1, 3'd1, 9'b110000000, 1'b0);
    addVec(op, z, 1'b1, 3'd2, 9'b111000000, 1'b0);
    addVec(op, z, 1'b1, 3'd3, 9'b111000000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(3'b010, 1'b0, 1'b1, 1'b0);

    // ALU op, no wait states
    addFetch(3'b010, 1'b0);
    addVec(3'b010, 0, 1, 3'd4, 9'b000010000, 0);
    addVec(3'b010, 0, 1, 3'd5, 9'b010000000, 0);
    addVec(3'b010, 0, 1, 3'd6, 9'b010000000, 0);
    addVec(3'b010, 0, 1, 3'd7, 9'b010001000, 0);
    // SKZ with zero=1; mem_ready low in non-memory-final phases is ignored
    addVec(3'b001, 1, 1, 3'd0, 9'b100000000, 0);
    addVec(3'b001, 1, 0, 3'd1, 9'b110000000, 0);
    addVec(3'b001, 1, 1, 3'd2, 9'b111000000, 0);
    addVec(3'b001, 1, 1, 3'd3, 9'b111000000, 0);
    addVec(3'b001, 1, 1, 3'd4, 9'b000010000, 0);
    addVec(3'b001, 1, 1, 3'd5, 9'b000000000, 0);
    addVec(3'b001, 1, 1, 3'd6, 9'b000010000, 0);
    addVec(3'b001, 1, 0, 3'd7, 9'b000000000, 0);
    // SKZ with zero=0
    addFetch(3'b001, 1'b0);
    addVec(3'b001, 0, 1, 3'd4, 9'b000010000, 0);
    addVec(3'b001, 0, 1, 3'd5, 9'b000000000, 0);
    addVec(3'b001, 0, 1, 3'd6, 9'b000000000, 0);
    addVec(3'b001, 0, 1, 3'd7, 9'b000000000, 0);
    // JMP; phase 7 is not memory-final for JMP
    addFetch(3'b111, 1'b0);
    addVec(3'b111, 0, 1, 3'd4, 9'b000010000, 0);
    addVec(3'b111, 0, 1, 3'd5, 9'b000000000, 0);
    addVec(3'b111, 0, 1, 3'd6, 9'b000000100, 0);
    addVec(3'b111, 0, 0, 3'd7, 9'b000000100, 0);
    // STO with two wait states in phase 7: 10 cycles phase 0 to phase 0
    addFetch(3'b110, 1'b0);
    addVec(3'b110, 0, 1, 3'd4, 9'b000010000, 0);
    addVec(3'b110, 0, 1, 3'd5, 9'b000000000, 0);
    addVec(3'b110, 0, 1, 3'd6, 9'b000000001, 0);
    addVec(3'b110, 0, 0, 3'd7, 9'b000000011, 1);
    addVec(3'b110, 0, 0, 3'd7, 9'b000000011, 1);
    addVec(3'b110, 0, 1, 3'd7, 9'b000000011, 0);
    // ALU op with one wait state in phase 3
    addVec(3'b100, 0, 1, 3'd0, 9'b100000000, 0);
    addVec(3'b100, 0, 1, 3'd1, 9'b110000000, 0);
    addVec(3'b100, 0, 1, 3'd2, 9'b111000000, 0);
    addVec(3'b100, 0, 0, 3'd3, 9'b111000000, 1);
    addVec(3'b100, 0, 1, 3'd3, 9'b111000000, 0);
    addVec(3'b100, 0, 1, 3'd4, 9'b000010000, 0);
    addVec(3'b100, 0, 1, 3'd5, 9'b010000000, 0);
    addVec(3'b100, 0, 1, 3'd6, 9'b010000000, 0);
    addVec(3'b100, 0, 1, 3'd7, 9'b010001000, 0);

    // Outputs while reset is held
    #12;
    checkA("reset", 3'd0, 9'b100000000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Table-driven instruction sequences
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].z, vecs[i].mr, 1'b0);
      #1;
      checkA($sformatf("vec%0d", i), vecs[i].ph, vecs[i].stb, vecs[i].st, 1'b0, 1'b0);
      tick();
    end

    // HLT, then resume on A; B ignores run
    applyStimulus(3'b000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkA("hlt p4", 3'd4, 9'b000110000, 1'b0, 1'b0, 1'b0);
    tick();
    checkA("halted", 3'd0, 9'b000000000, 1'b0, 1'b1, 1'b0);
    checkOutput("B halted", 32'(bHalted), 32'd1);
    tick();
    checkA("halted hold", 3'd0, 9'b000000000, 1'b0, 1'b1, 1'b0);
    run = 1'b1;
    #1;
    checkA("run seen", 3'd0, 9'b000000000, 1'b0, 1'b1, 1'b0);
    tick();
    run = 1'b0;
    checkA("resumed", 3'd0, 9'b100000000, 1'b0, 1'b0, 1'b0);
    checkOutput("B stays halted", 32'(bHalted), 32'd1);
    checkOutput("B phase", 32'(bPhase), 32'd0);
    checkOutput("B strobes", 32'(bStrobes), 32'd0);
    tick();
    checkOutput("resumed p1", 32'(aPhase), 32'd1);
    checkOutput("B still halted", 32'(bHalted), 32'd1);

    // Timeout: 4 stalled cycles in phase 3, then ERROR on A only
    rstPulse();
    applyStimulus(3'b010, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    memReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkA($sformatf("to stall%0d", i), 3'd3, 9'b111000000, 1'b1, 1'b0, 1'b0);
      tick();
    end
    checkOutput("err bus_err", 32'(aBusErr), 32'd1);
    checkOutput("err halted", 32'(aHalted), 32'd1);
    checkOutput("err strobes", 32'(aStrobes), 32'd0);
    checkOutput("err stall", 32'(aStall), 32'd0);
    checkOutput("B no timeout", 32'(bBusErr), 32'd0);
    checkOutput("B still stalled", 32'(bStall), 32'd1);
    applyStimulus(3'b010, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("err sticky", 32'(aBusErr), 32'd1);
    run = 1'b0;
    rstPulse();
    checkA("err reset", 3'd0, 9'b100000000, 1'b0, 1'b0, 1'b0);

    // mem_ready arrives on the cycle wait count reaches MAX_WAIT
    for (int i = 0; i < 3; i++) tick();
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    memReady = 1'b1;
    #1;
    checkA("late ready", 3'd3, 9'b111000000, 1'b0, 1'b0, 1'b0);
    tick();
    checkA("late ready adv", 3'd4, 9'b000010000, 1'b0, 1'b0, 1'b0);

    // Reset while stalled in phase 7 of a STO
    opcode = 3'b110;
    for (int i = 0; i < 3; i++) tick();
    memReady = 1'b0;
    tick();
    checkA("sto stall", 3'd7, 9'b000000011, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkA("mid-stall rst", 3'd0, 9'b100000000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    memReady = 1'b1;
    tick();
    checkOutput("after rst p1", 32'(aPhase), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
# seq_controller

Phase-sequencing controller for the accumulator CPU, and the next generation of the instruction-phase decoder. It owns its own 3-bit phase counter rather than taking phase from outside. It adds memory wait-state stalling with a timeout, a latched halt state with optional resume, and status outputs. It sits between the instruction register and the datapath, driving the same nine control strobes to the PC, IR, accumulator, ALU and memory interface.

## Interface
- WAIT_W, 4: width of the wait-state counter.
- MAX_WAIT, 15: last allowed stall count before bus error; 0 disables the timeout. Must be < 2^WAIT_W.
- RESUME_EN, 1: 1 lets `run` restart from HALTED; 0 makes HALTED exit only via reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  3  current IR opcode: 000 HLT, 001 SKZ, 010–101 ALU ops, 110 STO, 111 JMP.
- zero  in  1  accumulator-zero flag, sampled combinationally in phase 6.
- mem_ready  in  1  memory completion; low stalls a memory-final phase.
- run  in  1  resume request, level-sampled in HALTED only.
- sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e  out  1 each  datapath control strobes.
- phase  out  3  current phase counter value.
- stall  out  1  phase is being held for memory.
- halted  out  1  FSM is in HALTED or ERROR.
- bus_err  out  1  FSM is in ERROR (wait timeout).

## Operation
- States:
  - RUN: the phase advances.
  - HALTED: the phase is held at 0 and all nine strobes are 0.
  - ERROR: all nine strobes are 0; exited only by reset.
- Strobe decode in RUN, as a function of phase and opcode; any strobe not listed is 0. aluop means opcode 010–101.
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phases 2 and 3: sel, rd, ld_ir.
  - Phase 4: inc_pc; halt = hlt.
  - Phase 5: rd = aluop.
  - Phase 6: rd = aluop; inc_pc = skz & zero; ld_pc = jmp; data_e = sto.
  - Phase 7: rd = aluop; ld_ac = aluop; ld_pc = jmp; wr = sto; data_e = sto.
- Memory-final phase: phase 3 always; phase 7 when aluop or sto.
- stall = RUN & memory-final phase & !mem_ready.
  - While stall is high, phase does not advance and the strobes hold their decoded values.
  - wait_cnt increments each stalled cycle and clears on any advance.
- Timeout: a stalled cycle with wait_cnt == MAX_WAIT (MAX_WAIT ≠ 0) causes the transition RUN→ERROR at that edge.
- Phase advance: in RUN with no stall, phase goes to phase+1, wrapping 7→0.
- Halt:
  - Phase 4 with opcode 000 asserts halt for that cycle.
  - At that edge the FSM goes RUN→HALTED and phase goes to 0.
- Resume: in HALTED with RESUME_EN=1 and run=1, the FSM goes HALTED→RUN and phase stays 0. The first RUN cycle is phase 0.
- mem_ready is ignored in phases that are not memory-final.
- run is ignored in RUN and ERROR.
- opcode is assumed stable from phase 4 onward; changes during phases 0–3 only affect decode where listed above.

## Timing
- Reset (async, immediate): state=RUN, phase=0, wait_cnt=0.
  - Outputs during and after reset: sel=1, all other strobes 0, stall=0, halted=0, bus_err=0 (stall=0 because phase 0 is not memory-final).
- Instruction latency with no wait states is 8 cycles; each stalled cycle adds 1.
- All strobes, stall, halted and bus_err are combinational from registered state plus inputs; no extra pipeline stage.
- Cycle counts:
  - HLT: HALTED is entered on the edge after phase 4, so halted=1 in the next cycle.
  - Resume: 1 cycle from run high to phase 0 in RUN.
  - Timeout: ERROR is entered after exactly MAX_WAIT+1 stalled cycles.
- Reset mid-stall, mid-halt or in ERROR returns immediately to the reset state.
- Simultaneous events:
  - mem_ready rising on the cycle where wait_cnt == MAX_WAIT: the phase advances and no error occurs.
  - A halt cannot coincide with a stall, because phase 4 is never memory-final.

## Test plan
- Reset release with mem_ready=1, opcode=010 → phases 0..7 in 8 cycles; rd high in phases 1,2,3,5,6,7; ld_ir in phases 2–3; ld_ac only in phase 7; inc_pc only in phase 4.
- opcode=001 with zero=1, then with zero=0 → inc_pc in phases 4 and 6, then in phase 4 only.
- opcode=110 with mem_ready low for 2 cycles at phase 7 → stall=1 for 2 cycles, wr/data_e held; phase 0 is reached 10 cycles after the phase-0 start.
- MAX_WAIT=3 with mem_ready held low at phase 3 → 4 stall cycles, then bus_err=1, halted=1, all strobes 0; only rst recovers.
- opcode=000 → halt=1 in phase 4, then halted=1 with phase=0.
  - RESUME_EN=1: a run pulse returns to RUN at phase 0 one cycle later.
  - RESUME_EN=0: the run pulse is ignored.
- Assert rst mid-stall at phase 7 → outputs immediately sel=1, others 0, phase=0, stall=0.
